// File: rtl/hpm_trace_pkg.sv
// hpm_trace_pkg
//   Shared definitions for the HPM event trace block: slot register
//   addresses, CTRL/STATUS field positions, default sizing and the
//   layout of one trace entry (event mask in the top bits, timestamp below).
package hpm_trace_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_TS_W  = 29;
    localparam int EVT_W         = 3;
    localparam int ENTRY_W       = EVT_W + DEFAULT_TS_W;

    // Slot register map
    localparam logic [4:0] ADDR_CTRL   = 5'd0;
    localparam logic [4:0] ADDR_STATUS = 5'd1;
    localparam logic [4:0] ADDR_DATA   = 5'd2;
    localparam logic [4:0] ADDR_POP    = 5'd3;
    localparam logic [4:0] ADDR_TS     = 5'd4;

    // CTRL fields
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MASK_LSB = 1;
    localparam int CTRL_CLR_BIT  = 4;

    // STATUS fields
    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int STATUS_COUNT_W   = 7;
    localparam int STATUS_DROP_LSB  = 16;
    localparam int STATUS_DROP_W    = 16;

    // Event bit positions inside the mask / hit vector
    localparam int EVT_INST   = 0;
    localparam int EVT_MEM_RD = 1;
    localparam int EVT_MEM_WR = 2;

    typedef struct packed {
        logic [EVT_W-1:0]        mask;
        logic [DEFAULT_TS_W-1:0] ts;
    } trace_entry_t;

    function automatic trace_entry_t make_entry(
        input logic [EVT_W-1:0]        hit,
        input logic [DEFAULT_TS_W-1:0] ts
    );
        trace_entry_t e;
        e.mask = hit;
        e.ts   = ts;
        return e;
    endfunction

endpackage

// File: rtl/hpm_trace_fifo.sv
// hpm_trace_fifo
//   Synchronous FIFO holding trace entries. The head is read
//   combinationally so a push is visible at the output the next cycle.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, pop, flush  requests; flush wins over push/pop
//   data              entry to push
//   head              oldest entry (undefined when empty)
//   count, full, empty occupancy
module hpm_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    // a push that coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage has no reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= data;
        end
    end

    assign head = mem[rd_ptr_reg];

endmodule

// File: rtl/hpm_event_trace_core.sv
// hpm_event_trace_core
//   Captures timestamped CPU performance events (instruction retire,
//   memory read, memory write) into a trace FIFO readable over a simple
//   register slot.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cs, read, write, addr      slot access (read strobe has no side effects)
//   wr_data / rd_data          slot data; rd_data is a combinational decode
//   probe_inst, probe_mem_rd,
//   probe_mem_wr               one event per high cycle
module hpm_event_trace_core
    import hpm_trace_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TS_W  = DEFAULT_TS_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        probe_inst,
    input  logic        probe_mem_rd,
    input  logic        probe_mem_wr
);

    logic                   en_reg;
    logic [EVT_W-1:0]       mask_reg;
    logic [TS_W-1:0]        ts_reg;
    logic [STATUS_DROP_W-1:0] drop_reg;

    logic                   wr_en;
    logic                   ctrl_wr;
    logic                   clear;
    logic                   pop_req;
    logic                   push_req;
    logic                   drop_evt;
    logic [EVT_W-1:0]       probes;
    logic [EVT_W-1:0]       hit;
    trace_entry_t           entry;

    logic [ENTRY_W-1:0]     fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic [31:0]            status_word;
    logic                   unused_inputs;

    // The read strobe and the upper write-data bits carry no function.
    assign unused_inputs = ^{read, wr_data[31:5]};

    assign wr_en   = cs & write;
    assign ctrl_wr = wr_en && (addr == ADDR_CTRL);
    assign clear   = ctrl_wr && wr_data[CTRL_CLR_BIT];
    assign pop_req = wr_en && (addr == ADDR_POP);

    assign probes = {probe_mem_wr, probe_mem_rd, probe_inst};

    genvar gi;
    generate
        for (gi = 0; gi < EVT_W; gi++) begin : g_hit
            assign hit[gi] = probes[gi] & mask_reg[gi];
        end
    endgenerate

    assign push_req = en_reg && (hit != '0);
    assign entry    = make_entry(hit, DEFAULT_TS_W'(ts_reg));

    // A push is lost (and counted) only when the FIFO is full and nothing
    // leaves it this cycle. A clear swallows the event without counting.
    assign drop_evt = push_req && fifo_full && !pop_req && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_reg   <= 1'b0;
            mask_reg <= '0;
        end else if (ctrl_wr) begin
            en_reg   <= wr_data[CTRL_EN_BIT];
            mask_reg <= wr_data[CTRL_MASK_LSB +: EVT_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_reg <= '0;
        end else if (clear) begin
            ts_reg <= '0;
        end else if (en_reg) begin
            ts_reg <= ts_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_reg <= '0;
        end else if (clear) begin
            drop_reg <= '0;
        end else if (drop_evt && (drop_reg != '1)) begin
            drop_reg <= drop_reg + 1'b1;
        end
    end

    hpm_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req & ~clear),
        .pop   (pop_req & ~clear),
        .flush (clear),
        .data  (entry),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_word = '0;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
        status_word[STATUS_DROP_LSB +: STATUS_DROP_W]   = drop_reg;
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_CTRL:   rd_data = 32'({mask_reg, en_reg});
            ADDR_STATUS: rd_data = status_word;
            ADDR_DATA:   rd_data = fifo_empty ? 32'h0 : 32'(fifo_head);
            ADDR_TS:     rd_data = 32'(ts_reg);
            default:     rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_hpm_event_trace_core.sv
module tb_hpm_event_trace_core;

    logic        clk;
    logic        reset;
    logic        cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        probe_inst, probe_mem_rd, probe_mem_wr;

    // Narrow-timestamp instance used to reach the all-ones wrap quickly.
    logic        s_cs, s_write;
    logic [4:0]  s_addr;
    logic [31:0] s_wr_data;
    logic [31:0] s_rd_data;
    logic        zero_bit;

    hpm_event_trace_core dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .read         (read),
        .write        (write),
        .addr         (addr),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .probe_inst   (probe_inst),
        .probe_mem_rd (probe_mem_rd),
        .probe_mem_wr (probe_mem_wr)
    );

    hpm_event_trace_core #(.DEPTH(4), .TS_W(4)) dut_small (
        .clk          (clk),
        .reset        (reset),
        .cs           (s_cs),
        .read         (zero_bit),
        .write        (s_write),
        .addr         (s_addr),
        .wr_data      (s_wr_data),
        .rd_data      (s_rd_data),
        .probe_inst   (zero_bit),
        .probe_mem_rd (zero_bit),
        .probe_mem_wr (zero_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    // Scoreboard and reference state for the main instance
    logic [31:0] sb[$];
    int unsigned drop_m;
    logic        en_m;
    logic [2:0]  mask_m;
    logic [28:0] ts_m;

    // Advance one clock, updating the reference model from the inputs
    // held during the cycle that is ending.
    task automatic tick();
        logic       wr;
        logic       clr;
        logic       pop;
        logic [2:0] hit;
        wr  = cs && write;
        clr = wr && (addr == 5'd0) && wr_data[4];
        pop = wr && (addr == 5'd3);
        hit = {probe_mem_wr, probe_mem_rd, probe_inst} & mask_m;
        if (clr) begin
            sb.delete();
            drop_m = 0;
        end else begin
            if (pop && sb.size() > 0) sb.delete(0);
            if (en_m && hit != 3'b000) begin
                if (sb.size() < 16) sb.push_back({hit, ts_m});
                else if (drop_m < 65535) drop_m++;
            end
        end
        if (clr) ts_m = '0;
        else if (en_m) ts_m = ts_m + 1'b1;
        if (wr && addr == 5'd0) begin
            en_m   = wr_data[0];
            mask_m = wr_data[3:1];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        addr = a; wr_data = d; cs = 1'b1; write = 1'b1;
        tick();
        cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        addr = a; cs = 1'b1; read = 1'b1;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[0]     = (sb.size() == 0);
        s[1]     = (sb.size() == 16);
        s[14:8]  = 7'(sb.size());
        s[31:16] = 16'(drop_m);
        return s;
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        bus_read(5'd1, v); checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=%h", v, 32'h1); end
        else $display("ok   reset_status %h", v);
        bus_read(5'd0, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=%h", v, 32'h0); end
        else $display("ok   reset_ctrl %h", v);
        reset = 1'b0;
        tick(); tick();
        bus_read(5'd4, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL disabled_ts_hold got=%h exp=%h", v, 32'h0); end
        else $display("ok   disabled_ts_hold %h", v);
        bus_read(5'd2, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL empty_data got=%h exp=%h", v, 32'h0); end
        else $display("ok   empty_data %h", v);
        bus_read(5'd7, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=%h", v, 32'h0); end
        else $display("ok   unmapped_read %h", v);
    endtask

    task automatic test_basic_capture();
        logic [31:0] v;
        bus_write(5'd0, 32'h3);
        repeat (5) tick();
        bus_read(5'd4, v); checks++;
        if (v !== 32'd5 || v !== 32'(ts_m)) begin errors++; $display("FAIL ts_count got=%h exp=%h", v, 32'd5); end
        else $display("ok   ts_count %h", v);
        probe_inst = 1'b1; tick(); probe_inst = 1'b0;
        bus_read(5'd1, v); checks++;
        if (v !== 32'h0000_0100 || v !== exp_status()) begin errors++; $display("FAIL capture_status got=%h exp=%h", v, 32'h100); end
        else $display("ok   capture_status %h", v);
        bus_read(5'd2, v); checks++;
        if (v !== 32'h2000_0005 || sb.size() == 0 || v !== sb[0]) begin errors++; $display("FAIL capture_data got=%h exp=%h", v, 32'h2000_0005); end
        else $display("ok   capture_data %h", v);
        bus_write(5'd3, 32'h0);
        bus_read(5'd1, v); checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL pop_status got=%h exp=%h", v, 32'h1); end
        else $display("ok   pop_status %h", v);
    endtask

    task automatic test_masking();
        logic [31:0] v;
        bus_write(5'd0, 32'h1F);
        repeat (9) tick();
        probe_inst = 1'b1; probe_mem_rd = 1'b1; probe_mem_wr = 1'b1;
        tick();
        probe_inst = 1'b0; probe_mem_rd = 1'b0; probe_mem_wr = 1'b0;
        bus_read(5'd1, v); checks++;
        if (v !== 32'h0000_0100) begin errors++; $display("FAIL all_probe_count got=%h exp=%h", v, 32'h100); end
        else $display("ok   all_probe_count %h", v);
        bus_read(5'd2, v); checks++;
        if (v !== 32'hE000_0009 || sb.size() == 0 || v !== sb[0]) begin errors++; $display("FAIL all_probe_data got=%h exp=%h", v, 32'hE000_0009); end
        else $display("ok   all_probe_data %h", v);
        bus_write(5'd3, 32'h0);
        bus_write(5'd0, 32'h5);
        bus_read(5'd0, v); checks++;
        if (v !== 32'h5) begin errors++; $display("FAIL ctrl_readback got=%h exp=%h", v, 32'h5); end
        else $display("ok   ctrl_readback %h", v);
        probe_inst = 1'b1; tick(); probe_inst = 1'b0;
        bus_read(5'd1, v); checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL masked_inst got=%h exp=%h", v, 32'h1); end
        else $display("ok   masked_inst %h", v);
        probe_mem_rd = 1'b1; tick(); probe_mem_rd = 1'b0;
        bus_read(5'd2, v); checks++;
        if (sb.size() != 1 || v[31:29] !== 3'b010 || v !== sb[0]) begin errors++; $display("FAIL mem_rd_entry got=%h exp=%h", v, (sb.size() > 0) ? sb[0] : 32'h0); end
        else $display("ok   mem_rd_entry %h", v);
        bus_write(5'd3, 32'h0);
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        bus_write(5'd0, 32'h13);
        probe_inst = 1'b1;
        repeat (20) tick();
        probe_inst = 1'b0;
        bus_read(5'd1, v); checks++;
        if (v !== 32'h0004_1002 || v !== exp_status()) begin errors++; $display("FAIL overflow_status got=%h exp=%h", v, 32'h0004_1002); end
        else $display("ok   overflow_status %h", v);
        bus_read(5'd2, v); checks++;
        if (v !== 32'h2000_0000 || v !== sb[0]) begin errors++; $display("FAIL overflow_oldest got=%h exp=%h", v, 32'h2000_0000); end
        else $display("ok   overflow_oldest %h", v);
    endtask

    task automatic test_full_pop();
        logic [31:0] v;
        logic [31:0] exp_new;
        logic [31:0] last;
        exp_new = {3'b001, ts_m};
        probe_inst = 1'b1;
        bus_write(5'd3, 32'h0);
        probe_inst = 1'b0;
        bus_read(5'd1, v); checks++;
        if (v !== 32'h0004_1002) begin errors++; $display("FAIL full_pop_status got=%h exp=%h", v, 32'h0004_1002); end
        else $display("ok   full_pop_status %h", v);
        last = '0;
        for (int i = 0; i < 16; i++) begin
            bus_read(5'd2, v); checks++;
            if (sb.size() == 0 || v !== sb[0]) begin errors++; $display("FAIL drain_%0d got=%h exp=%h", i, v, (sb.size() > 0) ? sb[0] : 32'h0); end
            else $display("ok   drain_%0d %h", i, v);
            last = v;
            bus_write(5'd3, 32'h0);
        end
        checks++;
        if (last !== exp_new) begin errors++; $display("FAIL new_tail got=%h exp=%h", last, exp_new); end
        else $display("ok   new_tail %h", last);
        bus_write(5'd3, 32'h0);
        bus_read(5'd1, v); checks++;
        if (v !== 32'h0004_0001) begin errors++; $display("FAIL empty_pop_status got=%h exp=%h", v, 32'h0004_0001); end
        else $display("ok   empty_pop_status %h", v);
    endtask

    task automatic test_clear_priority();
        logic [31:0] v;
        bus_write(5'd0, 32'h3);
        probe_inst = 1'b1;
        repeat (3) tick();
        bus_read(5'd1, v); checks++;
        if (v !== 32'h0004_0300) begin errors++; $display("FAIL pre_clear_status got=%h exp=%h", v, 32'h0004_0300); end
        else $display("ok   pre_clear_status %h", v);
        bus_write(5'd0, 32'h13);
        probe_inst = 1'b0;
        bus_read(5'd1, v); checks++;
        if (v !== 32'h1 || v !== exp_status()) begin errors++; $display("FAIL clear_status got=%h exp=%h", v, 32'h1); end
        else $display("ok   clear_status %h", v);
        bus_read(5'd4, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL clear_ts got=%h exp=%h", v, 32'h0); end
        else $display("ok   clear_ts %h", v);
        bus_read(5'd0, v); checks++;
        if (v !== 32'h3) begin errors++; $display("FAIL clear_ctrl got=%h exp=%h", v, 32'h3); end
        else $display("ok   clear_ctrl %h", v);
        tick();
        bus_read(5'd4, v); checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL post_clear_ts got=%h exp=%h", v, 32'h1); end
        else $display("ok   post_clear_ts %h", v);
    endtask

    // The narrow instance runs the same all-ones-to-zero wrap with TS_W=4.
    task automatic test_wrap();
        logic [31:0] v;
        s_addr = 5'd0; s_wr_data = 32'h1; s_cs = 1'b1; s_write = 1'b1;
        tick();
        s_cs = 1'b0; s_write = 1'b0;
        repeat (15) tick();
        s_addr = 5'd4; #1; v = s_rd_data; checks++;
        if (v !== 32'hF) begin errors++; $display("FAIL ts_all_ones got=%h exp=%h", v, 32'hF); end
        else $display("ok   ts_all_ones %h", v);
        tick();
        s_addr = 5'd4; #1; v = s_rd_data; checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL ts_wrap got=%h exp=%h", v, 32'h0); end
        else $display("ok   ts_wrap %h", v);
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] v;
        bus_write(5'd0, 32'h3);
        probe_inst = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        sb.delete(); drop_m = 0; en_m = 1'b0; mask_m = '0; ts_m = '0;
        #1;
        bus_read(5'd1, v); checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL mid_reset_status got=%h exp=%h", v, 32'h1); end
        else $display("ok   mid_reset_status %h", v);
        bus_read(5'd0, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mid_reset_ctrl got=%h exp=%h", v, 32'h0); end
        else $display("ok   mid_reset_ctrl %h", v);
        bus_read(5'd4, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mid_reset_ts got=%h exp=%h", v, 32'h0); end
        else $display("ok   mid_reset_ts %h", v);
        tick();
        reset = 1'b0;
        tick();
        probe_inst = 1'b0;
        bus_read(5'd1, v); checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL post_reset_status got=%h exp=%h", v, 32'h1); end
        else $display("ok   post_reset_status %h", v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        probe_inst = 1'b0; probe_mem_rd = 1'b0; probe_mem_wr = 1'b0;
        s_cs = 1'b0; s_write = 1'b0; s_addr = '0; s_wr_data = '0;
        zero_bit = 1'b0;
        drop_m = 0; en_m = 1'b0; mask_m = '0; ts_m = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        test_basic_capture();
        test_masking();
        test_overflow();
        test_full_pop();
        test_clear_priority();
        test_wrap();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
